// File: rtl/mdu.sv
// MIPS HI/LO multiply/divide unit. The latency of MULT/DIV is modelled with a
// down-counter and a registered busy flag. MTHI/MTLO write HI/LO in one cycle.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  // Handshake: start is only honoured in IDLE. While busy=1 every start is
  // dropped, and that includes a start that arrives on the completing edge.
  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [31:0]   a_q, b_q;

  logic [63:0]   prod;
  logic          res_wr;
  logic [31:0]   res_hi, res_lo;

  // The result is computed from the latched operands. It is only committed on
  // the final RUN edge, so HI/LO never show a partial value.
  always_comb begin
    prod   = '0;
    res_wr = 1'b0;
    res_hi = '0;
    res_lo = '0;
    case (op_q)
      4'd1: begin
        prod   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        res_wr = 1'b1;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      4'd2: begin
        prod   = {32'b0, a_q} * {32'b0, b_q};
        res_wr = 1'b1;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      4'd3: begin
        if (b_q != 32'd0) begin
          res_wr = 1'b1;
          if (a_q == 32'h8000_0000 && b_q == 32'hffff_ffff) begin
            res_lo = 32'h8000_0000;
            res_hi = 32'd0;
          end else begin
            res_lo = $signed(a_q) / $signed(b_q);
            res_hi = $signed(a_q) % $signed(b_q);
          end
        end
      end
      4'd4: begin
        if (b_q != 32'd0) begin
          res_wr = 1'b1;
          res_lo = a_q / b_q;
          res_hi = a_q % b_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (mdu_op)
              4'd1, 4'd2: begin
                op_q  <= mdu_op;
                a_q   <= a;
                b_q   <= b;
                cnt   <= CW'(MULT_CYCLES);
                busy  <= 1'b1;
                state <= RUN;
              end
              4'd3, 4'd4: begin
                op_q  <= mdu_op;
                a_q   <= a;
                b_q   <= b;
                cnt   <= CW'(DIV_CYCLES);
                busy  <= 1'b1;
                state <= RUN;
              end
              4'd5:    hi <= a;
              4'd6:    lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt == CW'(1)) begin
            if (res_wr) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: a cycle-level reference model built on 64-bit arithmetic,
// directed scenarios with literal expectations, then a randomized run.
module tb_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  mdu_op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // The reference model tracks how many busy cycles remain and which result
  // is pending. The result is computed with full-width integer arithmetic.
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_wr = 1'b0;

  always @(posedge clk) begin
    longint          sa, sb, sr;
    longint unsigned ua, ub, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (reset) begin
      m_left = 0; m_hi = '0; m_lo = '0; p_wr = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_wr) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (start) begin
      case (mdu_op)
        4'd1: begin sr = sa * sb; p_hi = sr[63:32]; p_lo = sr[31:0]; p_wr = 1'b1; m_left = MC; end
        4'd2: begin ur = ua * ub; p_hi = ur[63:32]; p_lo = ur[31:0]; p_wr = 1'b1; m_left = MC; end
        4'd3: begin
          p_wr = (b != 32'd0);
          if (p_wr) begin sr = sa / sb; p_lo = sr[31:0]; sr = sa % sb; p_hi = sr[31:0]; end
          m_left = DC;
        end
        4'd4: begin
          p_wr = (b != 32'd0);
          if (p_wr) begin ur = ua / ub; p_lo = ur[31:0]; ur = ua % ub; p_hi = ur[31:0]; end
          m_left = DC;
        end
        4'd5: m_hi = a;
        4'd6: m_lo = a;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", {31'b0, busy}, {31'b0, (m_left > 0)});
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
    end
  end

  // Present one op for a single edge; returns #1 after that edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(posedge clk); #1;
    start = 1'b1; mdu_op = op; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 4'd0;
  endtask

  // Counts the cycles busy remains high, bounded so the bench cannot hang.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL wait_idle timeout actual=busy expected=idle");
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hffff_ffff;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    reset = 1'b1; start = 1'b1; mdu_op = 4'd1; a = 32'd5; b = 32'd6;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    cmp_en = 1'b1;
    reset = 1'b0; start = 1'b0; mdu_op = 4'd0;
    @(posedge clk); #1;
    check("rst_no_start", {31'b0, busy}, 32'd0);

    issue(4'd1, 32'hffff_fffe, 32'd3);
    wait_idle(n);
    check("mult_busy_len", n, MC);
    check("mult_hi", hi, 32'hffff_ffff);
    check("mult_lo", lo, 32'hffff_fffa);
    check("model_mult_lo", m_lo, 32'hffff_fffa);
    issue(4'd2, 32'hffff_fffe, 32'd3);
    wait_idle(n);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hffff_fffa);

    issue(4'd3, 32'hffff_fff9, 32'd2);
    wait_idle(n);
    check("div_busy_len", n, DC);
    check("div_lo", lo, 32'hffff_fffd);
    check("div_hi", hi, 32'hffff_ffff);
    check("model_div_hi", m_hi, 32'hffff_ffff);
    issue(4'd4, 32'd7, 32'd2);
    wait_idle(n);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    issue(4'd5, 32'h1234_5678, 32'd0);
    check("mthi", hi, 32'h1234_5678);
    check("mthi_nobusy", {31'b0, busy}, 32'd0);
    issue(4'd6, 32'h9abc_def0, 32'd0);
    check("mtlo", lo, 32'h9abc_def0);
    issue(4'd4, 32'd99, 32'd0);
    wait_idle(n);
    check("div0_busy_len", n, DC);
    check("div0_hi", hi, 32'h1234_5678);
    check("div0_lo", lo, 32'h9abc_def0);

    // Starts during RUN must be dropped, including MTLO.
    issue(4'd1, 32'd5, 32'd7);
    start = 1'b1; mdu_op = 4'd6; a = 32'hdead_beef;
    @(posedge clk); #1;
    mdu_op = 4'd3; a = 32'd100; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 4'd0;
    wait_idle(n);
    check("run_ign_lo", lo, 32'd35);
    check("run_ign_hi", hi, 32'd0);
    @(posedge clk); #1;
    check("run_ign_nodiv", {31'b0, busy}, 32'd0);

    issue(4'd3, 32'd100, 32'd7);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    repeat (DC + 2) @(posedge clk);
    #1;
    check("midrst_nolate", lo, 32'd0);

    // Overflow divide, then a start held across the completion edge.
    issue(4'd3, 32'h8000_0000, 32'hffff_ffff);
    repeat (DC - 1) @(posedge clk);
    #1;
    start = 1'b1; mdu_op = 4'd1; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);
    check("ovf_edge_ignored", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 4'd0;
    check("after_edge_accepted", {31'b0, busy}, 32'd1);
    wait_idle(n);
    check("b2b_lo", lo, 32'd6);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset  = ($urandom_range(0, 199) == 0);
      start  = ($urandom_range(0, 2) == 0);
      mdu_op = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 6));
      a      = rnd_val();
      b      = rnd_val();
    end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; mdu_op = 4'd0;
    repeat (DC + 3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
